// File: rtl/fft_pkg.sv
// Shared FFT datapath types: one complex sample as a packed signed re/im pair.
package fft_pkg;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } complex_t;
endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle for the bit-reverse reorder buffer: unstalled input, valid/ready output.
// Carries dout_sof when FFT_BITREV_SOF_EN is defined.
interface fft_bitrev_reorder_if;
  import fft_pkg::*;

  complex_t din;
  logic     din_valid;
  complex_t dout;
  logic     dout_valid;
  logic     dout_ready;
  logic     overflow;
`ifdef FFT_BITREV_SOF_EN
  logic     dout_sof;

  modport slave  (input  din, din_valid, dout_ready,
                  output dout, dout_valid, overflow, dout_sof);
  modport master (output din, din_valid, dout_ready,
                  input  dout, dout_valid, overflow, dout_sof);
`else
  modport slave  (input  din, din_valid, dout_ready,
                  output dout, dout_valid, overflow);
  modport master (output din, din_valid, dout_ready,
                  input  dout, dout_valid, overflow);
`endif
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed bin order, leave in natural order.
// Optional start-of-frame flag on the output when FFT_BITREV_SOF_EN is defined.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int LOG2N = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  fft_bitrev_reorder_if.slave io
);

  localparam int N = 1 << LOG2N;
  typedef logic [LOG2N-1:0] idx_t;
  localparam idx_t IDX_LAST = '1;

  function automatic idx_t bitrev(input idx_t k);
    idx_t r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

  complex_t r_mem0 [N];
  complex_t r_mem1 [N];

  logic [1:0] r_full;
  idx_t       r_wr_idx;
  logic       r_wr_bank;
  idx_t       r_rd_idx;
  logic       r_rd_bank;
  logic       r_overflow;
  complex_t   r_dout;
  logic       r_dout_valid;

  logic       w_wr_acc;
  logic       w_wr_last;
  idx_t       w_wr_addr;
  logic       w_load;
  logic       w_rd_last;
  complex_t   w_rd_data;
  logic [1:0] w_full_nxt;

  assign w_wr_acc  = io.din_valid && !r_full[r_wr_bank];
  assign w_wr_last = w_wr_acc && (r_wr_idx == IDX_LAST);
  assign w_wr_addr = bitrev(r_wr_idx);
  assign w_load    = r_full[r_rd_bank] && (!r_dout_valid || io.dout_ready);
  assign w_rd_last = w_load && (r_rd_idx == IDX_LAST);
  assign w_rd_data = r_rd_bank ? r_mem1[r_rd_idx] : r_mem0[r_rd_idx];

  // Writer only fills an empty bank and reader only drains a full one, so the
  // set and clear below can never target the same bank in one cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      if (r_wr_bank) r_mem1[w_wr_addr] <= io.din;
      else           r_mem0[w_wr_addr] <= io.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= 2'b00;
      r_wr_idx   <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_idx   <= '0;
      r_rd_bank  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_full     <= w_full_nxt;
      r_overflow <= io.din_valid && r_full[r_wr_bank];
      if (w_wr_acc) begin
        r_wr_idx <= r_wr_idx + 1'b1;
        if (w_wr_last) r_wr_bank <= ~r_wr_bank;
      end
      if (w_load) begin
        r_rd_idx <= r_rd_idx + 1'b1;
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Output register: loads on a free slot, otherwise holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_load) begin
      r_dout       <= w_rd_data;
      r_dout_valid <= 1'b1;
    end else if (io.dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign io.dout       = r_dout;
  assign io.dout_valid = r_dout_valid;
  assign io.overflow   = r_overflow;

`ifdef FFT_BITREV_SOF_EN
  logic r_dout_sof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_dout_sof <= 1'b0;
    else if (w_load) r_dout_sof <= (r_rd_idx == '0);
  end

  assign io.dout_sof = r_dout_sof;
`endif

endmodule
